ddr_scan_fetcher: RTL
=====================

// Module: ddr_scan_fetcher
// PURPOSE
//  Read-side client of the DDR controller for the VGA scan-out path. It walks a linear frame
//  buffer from BASE_ADDR and issues one 16-bit read per word over the controller's level
//  request/acknowledge handshake. Each returned word goes into a local FIFO, and the pixel
//  pipeline pops words from that FIFO. Same clock domain as the controller's command logic.
// PARAMETERS
//  ADDR_W      24       DDR word address width
//  DATA_W      16       DDR/pixel word width
//  FIFO_DEPTH  16       FIFO entries (power of 2)
//  FRAME_WORDS 307200   words per frame (640x480)
//  BASE_ADDR   24'h0    first word address of frame
// PORTS
//  clk            in   1       fetch clock (same edge as controller command logic)
//  rst            in   1       reset, asynchronous, active-high
//  frame_start    in   1       1-cycle pulse: flush, restart fetch at BASE_ADDR
//  pix_pop        in   1       consume FIFO head this cycle
//  pix_data       out  DATA_W  FIFO head (combinational from storage)
//  pix_valid      out  1       FIFO not empty
//  underflow      out  1       1-cycle pulse: pix_pop while !pix_valid
//  ddr_read       out  1       read request (level), to controller 'read'
//  ddr_read_addr  out  ADDR_W  request address, stable while ddr_read=1
//  ddr_read_ack   in   1       controller readAcknowledge
//  ddr_read_data  in   DATA_W  controller readData, valid when ack=1
//  busy           out  1       frame fetch in progress
// BEHAVIOUR
//  Reset state:
//   - all outputs 0; FIFO empty; state IDLE; word_cnt=0; addr=BASE_ADDR; active=0.
//  FSM states: IDLE, REQ, RELEASE.
//   - IDLE: if active && fifo_count<FIFO_DEPTH -> REQ, ddr_read<=1 (next cycle).
//   - REQ: hold ddr_read, addr. On ack=1: push ddr_read_data (unless discard set),
//     ddr_read<=0, addr+1, word_cnt+1 -> RELEASE.
//   - RELEASE: wait ack=0, because the controller clears ack only after read drops,
//     then -> IDLE. A new request never issues while ack=1.
//  Frame accounting:
//   - On the capture of word FRAME_WORDS-1: active<=0, addr<=BASE_ADDR, word_cnt<=0.
//   - No wrap beyond the frame; the next frame needs frame_start.
//  Handshake details:
//   - One outstanding read max; room checked at issue, pops only add room, so no overflow.
//   - Latency frame_start -> first ddr_read = 2 cycles (flush, then IDLE->REQ).
//  FIFO: push and pop in same cycle -> count unchanged. Pop on empty ignored, underflow=1.
//  frame_start while IDLE/RELEASE:
//   - flush FIFO, addr<=BASE_ADDR, word_cnt<=0, active<=1.
//  frame_start while REQ:
//   - in-flight read is not aborted; set discard; the returned word is dropped and
//     addr/cnt are not advanced.
//   - flush happens immediately; discard clears on leaving RELEASE.
//  busy = active || state!=IDLE.
//  rst mid-handshake drops ddr_read asynchronously. The controller is reset on the same rst.
// CONFIGURATION
//  DDR_FETCH_STATS_EN defined:
//   - adds output underflow_count[15:0]: saturating count of underflow pulses.
//   - clears on rst or frame_start.
//  Undefined: port absent; underflow pulse still generated.
// STRUCTURE
//  Shared package ddr_pkg:
//   - DDR_ADDR_W=24, DDR_DATA_W=16, fetch_state_t enum {IDLE,REQ,RELEASE}.
//  Sub-module sync_fifo (DATA_W, DEPTH): push/pop/flush, count, empty, head.
//   - Instantiated once; reusable by the write-side client.
// TESTING (bench models controller: ack N cycles after read, ack cleared 1 cycle after read drops)
//  1 rst, frame_start, FRAME_WORDS=8, ack delay 5, no pops:
//    addrs 0..7 issued, FIFO holds 8 words, busy falls after word 7.
//  2 FIFO_DEPTH=4, no pops: exactly 4 reads.
//    pop 1 -> one more read at addr 4; ddr_read never rises while ack=1.
//  3 Continuous pop at 1/3 rate: data order equals memory model contents 0..7.
//    underflow never asserts once pix_valid first rises and the fetch keeps up.
//  4 frame_start during REQ at addr 3: the returned word is discarded, FIFO empty.
//    next request addr=BASE_ADDR after RELEASE.
//  5 pix_pop on empty -> underflow pulse 1 cycle; with DDR_FETCH_STATS_EN, count increments to 1.
//    count saturates at 16'hFFFF under forced 70000 underflows.
//  6 rst asserted while ddr_read=1: ddr_read=0 same cycle (async), busy=0, pix_valid=0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR controller clients: word widths and the
// read-fetch state encoding.
package ddr_pkg;

    localparam int DDR_ADDR_W = 24;
    localparam int DDR_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, occupancy count and a combinational head.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty && !flush;
    assign do_push_s = push && !flush && (!full_s || do_pop_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (!do_push_s && do_pop_s) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/ddr_scan_fetcher.sv
// Scan-out read client: walks the frame buffer one word per DDR read handshake
// into a local FIFO. Optional DDR_FETCH_STATS_EN adds a saturating underflow counter.
module ddr_scan_fetcher
    import ddr_pkg::*;
#(
    parameter int              ADDR_W      = DDR_ADDR_W,
    parameter int              DATA_W      = DDR_DATA_W,
    parameter int              FIFO_DEPTH  = 16,
    parameter int              FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic              ddr_read,
    output logic [ADDR_W-1:0] ddr_read_addr,
    input  logic              ddr_read_ack,
    input  logic [DATA_W-1:0] ddr_read_data,
    output logic              busy
`ifdef DDR_FETCH_STATS_EN
    ,
    output logic [15:0]       underflow_count
`endif
);

    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic              active_r;
    logic              discard_r;
    logic              push_s;
    logic              fifo_empty_s;
    logic              fifo_room_s;
    logic [FCNT_W-1:0] fifo_count_s;

    // A word returned for a request that straddled a restart belongs to the old frame.
    assign push_s        = (state_r == REQ) && ddr_read_ack && !discard_r && !frame_start;
    assign fifo_room_s   = (fifo_count_s < FCNT_W'(FIFO_DEPTH));
    assign pix_valid     = !fifo_empty_s;
    assign ddr_read_addr = addr_r;
    assign busy          = active_r || (state_r != IDLE);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pix_pop),
        .flush (frame_start),
        .wdata (ddr_read_data),
        .head  (pix_data),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    // Read handshake FSM with frame address/word accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ddr_read   <= 1'b0;
            addr_r     <= BASE_ADDR;
            word_cnt_r <= {CNT_W{1'b0}};
            active_r   <= 1'b0;
            discard_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        addr_r     <= BASE_ADDR;
                        word_cnt_r <= {CNT_W{1'b0}};
                        active_r   <= 1'b1;
                    end else if (active_r && fifo_room_s) begin
                        state_r  <= REQ;
                        ddr_read <= 1'b1;
                    end
                end
                REQ: begin
                    // The address must stay put while the request is up, so a
                    // restart only takes effect once the in-flight read returns.
                    if (frame_start) begin
                        discard_r <= 1'b1;
                        active_r  <= 1'b1;
                    end
                    if (ddr_read_ack) begin
                        ddr_read <= 1'b0;
                        state_r  <= RELEASE;
                        if (discard_r || frame_start) begin
                            addr_r     <= BASE_ADDR;
                            word_cnt_r <= {CNT_W{1'b0}};
                        end else if (word_cnt_r == LAST_WORD) begin
                            active_r   <= 1'b0;
                            addr_r     <= BASE_ADDR;
                            word_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            addr_r     <= addr_r + ADDR_W'(1);
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (frame_start) begin
                        addr_r     <= BASE_ADDR;
                        word_cnt_r <= {CNT_W{1'b0}};
                        active_r   <= 1'b1;
                    end
                    if (!ddr_read_ack) begin
                        state_r   <= IDLE;
                        discard_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ddr_read <= 1'b0;
                end
            endcase
        end
    end

    // Underflow pulse for a pop against an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else begin
            underflow <= pix_pop && fifo_empty_s;
        end
    end

`ifdef DDR_FETCH_STATS_EN
    // Saturating underflow statistic, restarted with each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_count <= 16'h0000;
        end else if (frame_start) begin
            underflow_count <= 16'h0000;
        end else if (pix_pop && fifo_empty_s && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'h0001;
        end else begin
            underflow_count <= underflow_count;
        end
    end
`endif

endmodule
